soc2_commit_monitor: RTL and testbench
======================================

# soc2_commit_monitor

Synthesizable end-of-test monitor that sits directly downstream of the CPU writeback/retire stage in `soc2_top`. It consumes the retired-PC stream and the register-file write port. It keeps a shadow copy of one architectural register and detects retirement of a halt PC. It then latches a sticky PASS/FAIL verdict, or TIMEOUT if retirement stalls. This lets on-board builds (LEDs/GPIO) and benches share one pass/fail mechanism.

## Interface
Parameters:
- `HALT_PC`, 32'h1c000020: retired PC that ends the test.
- `CHECK_REG`, 5: register index shadowed and checked; must be 1..31.
- `EXPECT_VAL`, 32'h0000005a: value `CHECK_REG` must hold at halt for PASS.
- `TIMEOUT`, 24'd1_000_000: maximum cycles allowed without a retirement; must be >= 1.

Ports (clock and reset first):
- `clk`: input, 1 bit. Core clock, the 25 MHz PLL output domain.
- `resetn`: input, 1 bit. Asynchronous, active-low reset.
- `retire_vld`: input, 1 bit. One instruction retires this cycle.
- `retire_pc`: input, 32 bits. PC of the retiring instruction (the `pc_w` value); qualified by `retire_vld`.
- `rf_wen`: input, 1 bit. Register-file write enable.
- `rf_waddr`: input, 5 bits. Register-file write address.
- `rf_wdata`: input, 32 bits. Register-file write data.
- `clear`: input, 1 bit. Synchronous restart of the verdict and counters.
- `done`: output, 1 bit. A verdict has been reached; sticky.
- `pass`: output, 1 bit. Verdict is PASS.
- `fail`: output, 1 bit. Verdict is FAIL or TIMEOUT.
- `timeout`: output, 1 bit. Verdict is TIMEOUT.
- `retire_cnt`: output, 32 bits. Number of retirements since reset/clear; saturating.
- `shadow_val`: output, 32 bits. Current shadow copy of `CHECK_REG`.

## Operation
- FSM states: RUN, PASS, FAIL, TOUT. Reset state is RUN.
- RUN → PASS when `retire_vld` and `retire_pc == HALT_PC` and the effective check value equals `EXPECT_VAL`.
- RUN → FAIL on the same halt retirement when the effective check value differs from `EXPECT_VAL`.
- RUN → TOUT when the idle counter reaches `TIMEOUT`, i.e. `TIMEOUT` consecutive cycles pass with `retire_vld` = 0.
- The effective check value is `rf_wdata` when `rf_wen && rf_waddr == CHECK_REG` in the same cycle (bypass), otherwise `shadow_val`.
- If a halt retirement and the timeout threshold land on the same cycle, the halt wins and no TOUT is taken.
- PASS, FAIL and TOUT are terminal; only `clear` or reset leaves them. `clear` returns the FSM to RUN.
- Shadow register:
  - Updated by every write with `rf_wen && rf_waddr == CHECK_REG`, in every state.
  - Writes to other addresses, and to r0, are ignored.
  - `clear` does not alter the shadow, because the register file is not cleared either.
- `retire_cnt` increments on `retire_vld` in RUN only and saturates at 32'hffffffff.
- Idle counter (24-bit):
  - Zeroed on any `retire_vld`, otherwise incremented in RUN.
  - Frozen in terminal states.
  - Never wraps, because it stops at `TIMEOUT`.
- `clear` has priority over every other event in its cycle. It zeroes `retire_cnt` and the idle counter, and forces the FSM to RUN. A halt retirement in that same cycle is ignored.
- Output decode, all registered: `done` = state != RUN; `pass` = PASS; `fail` = FAIL or TOUT; `timeout` = TOUT.
- Reset values: FSM RUN; `done`, `pass`, `fail`, `timeout` all 0; `retire_cnt` 0; `shadow_val` 0; idle counter 0.

## Timing
- Verdict latency is 1 cycle: a halt retirement in cycle N gives `done`/`pass`/`fail` high from cycle N+1.
- Timeout latency: with no retirement after cycle N, `timeout` is high in cycle N+`TIMEOUT`+1.
- `shadow_val` reflects a write in cycle N from cycle N+1.
- `retire_cnt` counts a retirement in cycle N from cycle N+1.
- Reset asserted mid-test clears everything asynchronously. Operation resumes on the first `clk` edge after `resetn` rises.
- No handshake: inputs are sampled every cycle and there is no backpressure to the CPU.

## Structure
- Package `soc2_mon_pkg` holds:
  - the FSM state typedef (2-bit encoding: RUN=0, PASS=1, FAIL=2, TOUT=3);
  - default constants for `HALT_PC`, `EXPECT_VAL` and `TIMEOUT`.
- One sub-module, `soc2_sat_counter` (parameterized width, inc/clr/max), is instantiated twice: for `retire_cnt` and for the idle counter.
- The FSM and shadow register live in the top of the block.

## Test plan
- Write r5=0x5a, then retire 0x1c000020 → `pass`=1 and `done`=1 the next cycle, `fail`=0; the flags stay set over 100 further retirements.
- Write r5=0x0f, then retire 0x1c000020 → `fail`=1, `pass`=0, `timeout`=0.
- Write r5=0x5a and retire 0x1c000020 in the same cycle, with the old shadow at 0 → `pass`=1, proving the bypass.
- Run with `TIMEOUT`=16 and stop retiring after a retirement in cycle N → `timeout`=`fail`=1 in cycle N+17. The same setup with a halt retired in exactly cycle N+16 → `pass`.
- Reach PASS, then pulse `clear` while retiring the halt PC → FSM in RUN, `retire_cnt`=0, `shadow_val` still 0x5a. The next halt retirement → `pass`=1.
- Assert `resetn`=0 mid-run after 10 retirements → all outputs read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/soc2_mon_pkg.sv
// Shared types and default constants for the SoC2 end-of-test commit monitor.
package soc2_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } mon_state_e;

  localparam logic [31:0] DEF_HALT_PC    = 32'h1c00_0020;
  localparam logic [31:0] DEF_EXPECT_VAL = 32'h0000_005a;
  localparam logic [23:0] DEF_TIMEOUT    = 24'd1_000_000;

endpackage

// File: rtl/soc2_sat_counter.sv
// Up-counter that holds at MAX; clr wins over inc.
module soc2_sat_counter #(
  parameter int           W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != MAX)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/soc2_commit_monitor.sv
// Watches the retire stream and RF write port; latches a sticky PASS/FAIL/TIMEOUT verdict.
module soc2_commit_monitor
  import soc2_mon_pkg::*;
#(
  parameter logic [31:0] HALT_PC    = DEF_HALT_PC,
  parameter logic [4:0]  CHECK_REG  = 5'd5,
  parameter logic [31:0] EXPECT_VAL = DEF_EXPECT_VAL,
  parameter logic [23:0] TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        retire_vld,
  input  logic [31:0] retire_pc,
  input  logic        rf_wen,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  input  logic        clear,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] retire_cnt,
  output logic [31:0] shadow_val
);

  mon_state_e  state;
  logic [23:0] idle_cnt;
  logic        run, chk_wr, halt, idle_hit;
  logic [31:0] eff_val;

  assign run     = (state == ST_RUN);
  assign chk_wr  = rf_wen && (rf_waddr == CHECK_REG) && (rf_waddr != 5'd0);
  // Same-cycle write to the checked register must be seen by a halt retiring alongside it.
  assign eff_val = chk_wr ? rf_wdata : shadow_val;
  assign halt    = retire_vld && (retire_pc == HALT_PC);
  // Fires on the TIMEOUT-th idle cycle so the verdict lands one cycle later.
  assign idle_hit = !retire_vld && (idle_cnt == TIMEOUT - 24'd1);

  soc2_sat_counter #(.W(32), .MAX(32'hffff_ffff)) u_retire_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (run && retire_vld),
    .clr    (clear),
    .cnt    (retire_cnt)
  );

  soc2_sat_counter #(.W(24), .MAX(TIMEOUT)) u_idle_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (run && !retire_vld),
    .clr    (clear || (run && retire_vld)),
    .cnt    (idle_cnt)
  );

  // Shadow tracks the register file, which clear does not touch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     shadow_val <= '0;
    else if (chk_wr) shadow_val <= rf_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else if (clear) begin
      state   <= ST_RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            done <= 1'b1;
            if (eff_val == EXPECT_VAL) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end
          end else if (idle_hit) begin
            state   <= ST_TOUT;
            done    <= 1'b1;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc2_commit_monitor.sv
// Randomized and directed checks of soc2_commit_monitor against a timestamp-based verdict model.
module tb_soc2_commit_monitor;

  localparam logic [31:0] HALT = 32'h1c00_0020;
  localparam logic [31:0] EXPV = 32'h0000_005a;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        retire_vld = 1'b0;
  logic [31:0] retire_pc = '0;
  logic        rf_wen = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        clear = 1'b0;
  logic        done, pass, fail, timeout;
  logic [31:0] retire_cnt, shadow_val;

  soc2_commit_monitor #(.TIMEOUT(24'd16)) dut (
    .clk(clk), .resetn(resetn), .retire_vld(retire_vld), .retire_pc(retire_pc),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .clear(clear),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .retire_cnt(retire_cnt), .shadow_val(shadow_val)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;

  // Model: verdict 0=none 1=pass 2=fail 3=timeout; idle measured from the last retire/clear cycle.
  int          m_verdict;
  logic [31:0] m_cnt, m_shadow;
  longint      mcyc = 0, last_ret = -1;

  task automatic model_reset();
    m_verdict = 0; m_cnt = 0; m_shadow = 0; last_ret = mcyc - 1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p = $urandom;
    if (p == HALT) p = p ^ 32'h1;
    return p;
  endfunction

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic cycle(input logic rv, input logic [31:0] pc, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd, input logic clr);
    logic [31:0] eff;
    retire_vld = rv; retire_pc = pc; rf_wen = wen; rf_waddr = wa; rf_wdata = wd; clear = clr;
    eff = (wen && wa == 5'd5) ? wd : m_shadow;
    if (clr) begin
      m_verdict = 0; m_cnt = 0; last_ret = mcyc;
    end else if (m_verdict == 0) begin
      if (rv) begin
        if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
        last_ret = mcyc;
        if (pc == HALT) m_verdict = (eff == EXPV) ? 1 : 2;
      end else if (mcyc - last_ret >= TO) begin
        m_verdict = 3;
      end
    end
    if (wen && wa == 5'd5) m_shadow = wd;
    @(posedge clk); #1;
    mcyc++;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    retire_vld = 0; rf_wen = 0; clear = 0;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    cmp++; if ({done, pass, fail, timeout} !== 4'b0) begin err++; $display("FAIL reset_flags got=%b exp=0000", {done, pass, fail, timeout}); end
    cmp++; if (retire_cnt !== 32'h0) begin err++; $display("FAIL reset_cnt got=%h exp=0", retire_cnt); end
    cmp++; if (shadow_val !== 32'h0) begin err++; $display("FAIL reset_shadow got=%h exp=0", shadow_val); end
    apply_reset();
  endtask

  task automatic test_pass();
    cycle(1'b0, 32'h0, 1'b1, 5'd5, EXPV, 1'b0);
    cycle(1'b1, HALT, 1'b0, 5'd0, 32'h0, 1'b0);
    cmp++; if ({done, pass, fail} !== 3'b110) begin err++; $display("FAIL pass_verdict got=%b exp=110", {done, pass, fail}); end
    for (int i = 0; i < 100; i++) cycle(1'b1, (i % 7 == 0) ? HALT : rand_pc(), 1'b0, 5'd0, 32'h0, 1'b0);
    cmp++; if ({done, pass, fail, timeout} !== 4'b1100) begin err++; $display("FAIL pass_sticky got=%b exp=1100", {done, pass, fail, timeout}); end
    cmp++; if (retire_cnt !== 32'd1) begin err++; $display("FAIL pass_cnt_frozen got=%0d exp=1", retire_cnt); end
  endtask

  task automatic test_fail();
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 5'd5, 32'h0f, 1'b0);
    cycle(1'b1, HALT, 1'b1, 5'd6, EXPV, 1'b0);
    cmp++; if ({done, pass, fail, timeout} !== 4'b1010) begin err++; $display("FAIL fail_verdict got=%b exp=1010", {done, pass, fail, timeout}); end
    cmp++; if (shadow_val !== 32'h0f) begin err++; $display("FAIL fail_shadow got=%h exp=0000000f", shadow_val); end
  endtask

  task automatic test_bypass();
    apply_reset();
    cycle(1'b1, HALT, 1'b1, 5'd5, EXPV, 1'b0);
    cmp++; if ({done, pass, fail} !== 3'b110) begin err++; $display("FAIL bypass_verdict got=%b exp=110", {done, pass, fail}); end
    cmp++; if (shadow_val !== EXPV) begin err++; $display("FAIL bypass_shadow got=%h exp=%h", shadow_val, EXPV); end
  endtask

  task automatic test_timeout();
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b1, rand_pc(), 1'b1, 5'd5, EXPV, 1'b0);
    for (int i = 0; i < TO - 1; i++) idle();
    cmp++; if (timeout !== 1'b0) begin err++; $display("FAIL tout_early got=%b exp=0", timeout); end
    idle();
    cmp++; if ({done, pass, fail, timeout} !== 4'b1011) begin err++; $display("FAIL tout_verdict got=%b exp=1011", {done, pass, fail, timeout}); end
    // Halt retired on the threshold cycle beats the timeout.
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b1, rand_pc(), 1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < TO - 1; i++) idle();
    cycle(1'b1, HALT, 1'b0, 5'd0, 32'h0, 1'b0);
    cmp++; if ({done, pass, fail, timeout} !== 4'b1100) begin err++; $display("FAIL tout_halt_wins got=%b exp=1100", {done, pass, fail, timeout}); end
  endtask

  task automatic test_clear();
    cycle(1'b1, HALT, 1'b0, 5'd0, 32'h0, 1'b1);
    cmp++; if ({done, pass, fail, timeout} !== 4'b0) begin err++; $display("FAIL clear_flags got=%b exp=0000", {done, pass, fail, timeout}); end
    cmp++; if (retire_cnt !== 32'h0) begin err++; $display("FAIL clear_cnt got=%0d exp=0", retire_cnt); end
    cmp++; if (shadow_val !== EXPV) begin err++; $display("FAIL clear_shadow got=%h exp=%h", shadow_val, EXPV); end
    cycle(1'b1, HALT, 1'b0, 5'd0, 32'h0, 1'b0);
    cmp++; if ({done, pass} !== 2'b11) begin err++; $display("FAIL clear_repass got=%b exp=11", {done, pass}); end
    cmp++; if (retire_cnt !== 32'd1) begin err++; $display("FAIL clear_repass_cnt got=%0d exp=1", retire_cnt); end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_pc(), 1'b1, 5'd5, 32'h33, 1'b0);
    cmp++; if (retire_cnt !== 32'd10) begin err++; $display("FAIL ares_pre_cnt got=%0d exp=10", retire_cnt); end
    #2 resetn = 1'b0;
    #1;
    cmp++; if ({done, pass, fail, timeout} !== 4'b0) begin err++; $display("FAIL ares_flags got=%b exp=0000", {done, pass, fail, timeout}); end
    cmp++; if (retire_cnt !== 32'h0 || shadow_val !== 32'h0) begin err++; $display("FAIL ares_regs cnt=%h shadow=%h exp=0/0", retire_cnt, shadow_val); end
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic busy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic        rv, wen, clr;
      logic [4:0]  wa;
      logic [31:0] pc, wd;
      if (i % 40 == 0) busy = ($urandom_range(0, 2) != 0);
      rv  = busy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 29) == 0);
      pc  = ($urandom_range(0, 9) == 0) ? HALT : rand_pc();
      wen = $urandom_range(0, 1);
      wa  = ($urandom_range(0, 2) == 0) ? 5'd5 : 5'($urandom_range(0, 31));
      wd  = $urandom_range(0, 1) ? EXPV : $urandom;
      clr = (m_verdict != 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      cycle(rv, pc, wen, wa, wd, clr);
      cmp++;
      if ({done, pass, fail, timeout} !== {m_verdict != 0, m_verdict == 1, m_verdict >= 2, m_verdict == 3}) begin
        err++;
        $display("FAIL rand_flags cyc=%0d got=%b exp_verdict=%0d", i, {done, pass, fail, timeout}, m_verdict);
      end
      cmp++;
      if (retire_cnt !== m_cnt || shadow_val !== m_shadow) begin
        err++;
        $display("FAIL rand_regs cyc=%0d cnt=%0d exp=%0d shadow=%h exp=%h", i, retire_cnt, m_cnt, shadow_val, m_shadow);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_bypass();
    test_timeout();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
